h_stepper: RTL and testbench
============================

# h_stepper

Sequential abscissa generator for the RK4 datapath. It consumes the step size produced by the H calculation, magnitude `H` plus `H_sign`, and walks the abscissa from `X_o` toward the endpoint. It emits `x_k = X_o ± k·H` for k = 0..N_steps, one point per valid/ready handshake, to the RK4 stage engine. It is the consumer/reconstruction side of the H calculation: it turns (X_o, H, N) back into the sequence of sample points that ends at C.

## Interface
Parameters:
- `n`, 32: data width; unsigned fixed-point Q16.16 magnitude.
- `KW`, 16: step-counter width.

Ports:
- `clk` input 1: system clock; all state updates on the rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `start` input 1: begin a run; sampled only in IDLE.
- `X_o` input n: start abscissa; unsigned Q16.16.
- `H` input n: step magnitude; unsigned Q16.16.
- `H_sign` input 1: 0 = step up (add H); 1 = step down (subtract H).
- `N_steps` input KW: number of steps; emits N_steps+1 points.
- `x_ready` input 1: downstream accepts `x_out` this cycle.
- `x_out` output n: current abscissa x_k.
- `k_out` output KW: index k of `x_out`.
- `x_valid` output 1: `x_out`/`k_out` valid.
- `busy` output 1: high in any state other than IDLE.
- `done` output 1: one-cycle pulse after the last point is accepted.
- `ovf` output 1: sticky; arithmetic left [0, 2^n−1] during this run.

## Operation
- States: IDLE, EMIT, DONE.
- **IDLE**
  - `start`=1 registers `X_o`, `H`, `H_sign`, `N_steps`, sets `x_out`=X_o and `k_out`=0, clears `ovf`, and goes to EMIT.
- **EMIT**
  - `x_valid`=1 throughout.
  - On a handshake (`x_valid & x_ready`) with `k_out` == N_steps: go to DONE.
  - On a handshake otherwise: `x_out` ← `x_out` ± H (per the registered `H_sign`), `k_out` ← `k_out`+1, stay in EMIT.
  - Without a handshake, `x_out` and `k_out` hold stable.
- **DONE**: `done`=1 for exactly one cycle, `x_valid`=0, then go to IDLE.
- `start` is ignored outside IDLE. Input changes after capture have no effect on the run.
- **Arithmetic**
  - Add/subtract is (n+1)-bit internally.
  - A carry out of bit n−1 on an add, or a borrow on a subtract, sets `ovf`. The stored value is set by Configuration.
- **Reset** (including mid-run) asynchronously forces IDLE. All outputs go to 0: `x_out`, `k_out`, `x_valid`, `busy`, `done`, `ovf`. No `done` pulse is issued for an aborted run.
- `N_steps`=0 emits only x_0, then DONE.
- `H`=0 emits N_steps+1 identical points and never sets `ovf`.

## Timing
- Latency: `start` is sampled at edge t. `x_valid`=1 with x_0 from edge t+1.
- Throughput: with `x_ready` held high, one point per cycle. Point k appears at edge t+1+k.
- `done` is high in the cycle after the last handshake. `busy` drops in the same cycle `done` falls; IDLE is entered at the following edge.
- Earliest next `start` acceptance: the cycle `busy`=0, i.e. 2 cycles after the last handshake.
- `x_valid` never deasserts within a run until the final handshake. `x_out`/`k_out` do not change while `x_valid & !x_ready`.
- `ovf` updates in the same edge as the offending `x_out`. It stays set until the next accepted `start` or `rst`.

## Configuration
- Macro `H_STEPPER_SATURATE_EN`.
- **Defined**
  - On overflow, `x_out` clamps to 2^n−1 on an add or 0 on a subtract.
  - A clamped value stays clamped on subsequent steps in the same direction.
- **Undefined**: `x_out` wraps modulo 2^n.
- `ovf` behaviour is identical in both builds.

## Test plan
- **Basic up-count.** X_o=0x0001_0000, H=0x0000_8000, H_sign=0, N_steps=4, `x_ready`=1 → `x_out`=0x0001_0000, 0x0001_8000, 0x0002_0000, 0x0002_8000, 0x0003_0000 on 5 consecutive cycles; `k_out` 0..4; `done` one cycle later; `ovf`=0.
- **Down-count with backpressure.** X_o=0x0003_0000, H=0x0001_0000, H_sign=1, N_steps=2, `x_ready` low 3 cycles at k=1 → x_1=0x0002_0000 held stable 3 cycles, then x_2=0x0001_0000; `done` after the final handshake.
- **Underflow.** X_o=0x0000_4000, H=0x0000_8000, H_sign=1, N_steps=1 → x_1=0x0000_0000 (SAT build) or 0xFFFF_C000 (wrap build); `ovf`=1 in both.
- **Zero steps.** N_steps=0, X_o=0x1234_5678 → a single point 0x1234_5678 with k=0, then `done`; `start` pulsed during EMIT is ignored.
- **Reset mid-run.** Assert `rst` at k=2 of N_steps=5 → all outputs 0 immediately, no `done`. A new `start` after release restarts at k=0 with the new X_o.

Source files
------------

// File: rtl/h_stepper.sv
// Abscissa walker: emits x_k = X_o +/- k*H for k = 0..N_steps over a valid/ready port.
// Build option H_STEPPER_SATURATE_EN clamps x_out on overflow instead of wrapping.
module h_stepper #(
   parameter int n  = 32,
   parameter int KW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic [n-1:0]  X_o,
   input  logic [n-1:0]  H,
   input  logic          H_sign,
   input  logic [KW-1:0] N_steps,
   input  logic          x_ready,
   output logic [n-1:0]  x_out,
   output logic [KW-1:0] k_out,
   output logic          x_valid,
   output logic          busy,
   output logic          done,
   output logic          ovf
);

   typedef enum logic [1:0] {IDLE, EMIT, DONE} state_t;

   state_t        state;
   logic [n-1:0]  h_q;
   logic          sign_q;
   logic [KW-1:0] n_q;

   logic [n:0]    sum_ext;
   logic [n:0]    diff_ext;
   logic [n-1:0]  x_next;
   logic          step_ovf;
   logic          hs;

   // A point transfers on any rising edge with x_valid & x_ready; while x_valid is
   // high and x_ready low, x_out/k_out are held and x_valid stays asserted.
   assign hs = x_valid & x_ready;

   always_comb begin
      sum_ext  = {1'b0, x_out} + {1'b0, h_q};
      diff_ext = {1'b0, x_out} - {1'b0, h_q};
      step_ovf = 1'b0;
      x_next   = x_out;
      if (sign_q) begin
         step_ovf = diff_ext[n];
         x_next   = diff_ext[n-1:0];
`ifdef H_STEPPER_SATURATE_EN
         if (diff_ext[n]) x_next = '0;
`endif
      end else begin
         step_ovf = sum_ext[n];
         x_next   = sum_ext[n-1:0];
`ifdef H_STEPPER_SATURATE_EN
         if (sum_ext[n]) x_next = '1;
`endif
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         h_q     <= '0;
         sign_q  <= 1'b0;
         n_q     <= '0;
         x_out   <= '0;
         k_out   <= '0;
         x_valid <= 1'b0;
         busy    <= 1'b0;
         done    <= 1'b0;
         ovf     <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  h_q     <= H;
                  sign_q  <= H_sign;
                  n_q     <= N_steps;
                  x_out   <= X_o;
                  k_out   <= '0;
                  ovf     <= 1'b0;
                  x_valid <= 1'b1;
                  busy    <= 1'b1;
                  state   <= EMIT;
               end
            end
            EMIT: begin
               if (hs) begin
                  if (k_out == n_q) begin
                     x_valid <= 1'b0;
                     done    <= 1'b1;
                     state   <= DONE;
                  end else begin
                     x_out <= x_next;
                     k_out <= k_out + 1'b1;
                     ovf   <= ovf | step_ovf;
                  end
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_h_stepper.sv
// Directed bench for h_stepper; expected points are hand-computed and queued in exp_q.
// Expected overflow values follow the H_STEPPER_SATURATE_EN build option.
module tb_h_stepper;

   localparam int W  = 32;
   localparam int KW = 16;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [W-1:0]  X_o;
   logic [W-1:0]  H;
   logic          H_sign;
   logic [KW-1:0] N_steps;
   logic          x_ready;
   logic [W-1:0]  x_out;
   logic [KW-1:0] k_out;
   logic          x_valid;
   logic          busy;
   logic          done;
   logic          ovf;

   int errors = 0;
   int checks = 0;
   logic [W-1:0] exp_q[$];

   h_stepper #(.n(W), .KW(KW)) dut (
      .clk(clk), .rst(rst), .start(start), .X_o(X_o), .H(H), .H_sign(H_sign),
      .N_steps(N_steps), .x_ready(x_ready), .x_out(x_out), .k_out(k_out),
      .x_valid(x_valid), .busy(busy), .done(done), .ovf(ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      checks++;
      if (obs !== expv) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, expv);
      end
   endtask

   // Called at a negedge; start is seen at the next posedge, x_0 at the following negedge.
   task automatic start_run(input logic [W-1:0] x0, input logic [W-1:0] h, input logic s,
                            input logic [KW-1:0] nn);
      X_o = x0; H = h; H_sign = s; N_steps = nn; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   // Checks points k0..k1 from exp_q, with x_ready high on every cycle.
   task automatic drain(input string tag, input int k0, input int k1);
      for (int k = k0; k <= k1; k++) begin
         check({tag, " valid"}, W'(x_valid), W'(1));
         check({tag, " x"}, x_out, exp_q.pop_front());
         check({tag, " k"}, W'(k_out), W'(k));
         @(negedge clk);
      end
   endtask

   task automatic finish_run(input string tag, input logic exp_ovf);
      check({tag, " done"}, W'(done), W'(1));
      check({tag, " valid_low"}, W'(x_valid), W'(0));
      check({tag, " busy_in_done"}, W'(busy), W'(1));
      check({tag, " ovf"}, W'(ovf), W'(exp_ovf));
      @(negedge clk);
      check({tag, " done_fall"}, W'(done), W'(0));
      check({tag, " busy_fall"}, W'(busy), W'(0));
      @(negedge clk);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " x"}, x_out, '0);
      check({tag, " k"}, W'(k_out), '0);
      check({tag, " valid"}, W'(x_valid), '0);
      check({tag, " busy"}, W'(busy), '0);
      check({tag, " done"}, W'(done), '0);
      check({tag, " ovf"}, W'(ovf), '0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; X_o = '0; H = '0; H_sign = 1'b0; N_steps = '0; x_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst = 1'b0;
      @(negedge clk);

      // basic up-count
      exp_q = '{32'h0001_0000, 32'h0001_8000, 32'h0002_0000, 32'h0002_8000, 32'h0003_0000};
      start_run(32'h0001_0000, 32'h0000_8000, 1'b0, 16'd4);
      drain("up", 0, 4);
      finish_run("up", 1'b0);

      // down-count with 3 cycles of backpressure at k=1
      start_run(32'h0003_0000, 32'h0001_0000, 1'b1, 16'd2);
      check("bp x0", x_out, 32'h0003_0000);
      @(negedge clk);
      x_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("bp hold valid", W'(x_valid), W'(1));
         check("bp hold x1", x_out, 32'h0002_0000);
         check("bp hold k1", W'(k_out), W'(1));
         if (i < 2) @(negedge clk);
      end
      x_ready = 1'b1;
      @(negedge clk);
      check("bp x2", x_out, 32'h0001_0000);
      check("bp k2", W'(k_out), W'(2));
      @(negedge clk);
      finish_run("bp", 1'b0);

      // underflow on subtract
`ifdef H_STEPPER_SATURATE_EN
      exp_q = '{32'h0000_4000, 32'h0000_0000};
`else
      exp_q = '{32'h0000_4000, 32'hFFFF_C000};
`endif
      start_run(32'h0000_4000, 32'h0000_8000, 1'b1, 16'd1);
      check("uf ovf_before", W'(ovf), W'(0));
      drain("uf", 0, 1);
      finish_run("uf", 1'b1);

      // overflow on add, clamped value stays clamped in the saturating build
`ifdef H_STEPPER_SATURATE_EN
      exp_q = '{32'hFFFF_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
`else
      exp_q = '{32'hFFFF_0000, 32'h0000_0000, 32'h0001_0000};
`endif
      start_run(32'hFFFF_0000, 32'h0001_0000, 1'b0, 16'd2);
      check("of ovf_cleared", W'(ovf), W'(0));
      drain("of", 0, 2);
      finish_run("of", 1'b1);

      // H=0 at the top of range: identical points, no overflow
      exp_q = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      start_run(32'hFFFF_FFFF, 32'h0, 1'b0, 16'd2);
      drain("h0", 0, 2);
      finish_run("h0", 1'b0);

      // zero steps; start during EMIT/DONE is ignored
      start_run(32'h1234_5678, 32'h0001_0000, 1'b0, 16'd0);
      x_ready = 1'b0; start = 1'b1; X_o = 32'hAAAA_0000; N_steps = 16'd7;
      @(negedge clk);
      check("z0 x_hold", x_out, 32'h1234_5678);
      check("z0 k_hold", W'(k_out), W'(0));
      check("z0 valid", W'(x_valid), W'(1));
      x_ready = 1'b1;
      @(negedge clk);
      check("z0 done", W'(done), W'(1));
      check("z0 x_after", x_out, 32'h1234_5678);
      start = 1'b0;
      @(negedge clk);
      check("z0 idle_busy", W'(busy), W'(0));
      check("z0 idle_valid", W'(x_valid), W'(0));
      @(negedge clk);
      check("z0 no_restart", W'(busy), W'(0));

      // reset mid-run at k=2, then restart
      start_run(32'h0, 32'h0001_0000, 1'b0, 16'd5);
      @(negedge clk);
      @(negedge clk);
      check("rr k2", W'(k_out), W'(2));
      check("rr x2", x_out, 32'h0002_0000);
      rst = 1'b1;
      #1;
      check_zero("rr async");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check_zero("rr after");
      exp_q = '{32'h0005_0000, 32'h0006_0000};
      start_run(32'h0005_0000, 32'h0001_0000, 1'b0, 16'd1);
      drain("rr new", 0, 1);
      finish_run("rr new", 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
